// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL  = 1'b1;
  localparam logic TX_START_LEVEL = 1'b0;

  localparam int unsigned PARITY_MAX_W = 64;

  // Even parity of a zero-extended word; the extension bits never change the result.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the wrap cycle.
// Kept generic so the receiver can reuse it.
module bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  localparam int unsigned TW = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  output logic          tick,
  output logic [TW-1:0] count
);

  localparam logic [TW-1:0] CNT_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] CNT_ONE  = TW'(32'd1);
  localparam logic [TW-1:0] CNT_LAST = TW'(CLKS_PER_BIT - 32'd1);

  logic [TW-1:0] count_r;

  // Period counter, held at zero while cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else if (clear) begin
      count_r <= CNT_ZERO;
    end else if (count_r == CNT_LAST) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_r + CNT_ONE;
    end
  end

  assign tick  = !clear && (count_r == CNT_LAST);
  assign count = count_r;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the upstream FIFO and sends each as a start/data/stop serial frame.
// Optional even parity bit: define FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned M            = 10,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         fifo_empty,
  input  logic [M-1:0] fifo_data,
  output logic         fifo_rd,
  output logic         tx,
  output logic         busy,
  output logic         frame_done
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(M) + 32'd1;

  localparam logic [IW-1:0] IDX_ZERO      = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE       = IW'(32'd1);
  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(M - 32'd1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 32'd1);
  // frame_done is registered, so it is armed one cycle before the final stop cycle
  localparam logic [TW-1:0] CNT_PRE_LAST  = TW'(CLKS_PER_BIT - 32'd2);

  tx_state_t     state_r, state_s;
  logic [M-1:0]  shift_r, shift_s;
  logic [IW-1:0] idx_r, idx_s;
  logic          tx_s, rd_s, busy_s, done_s;
  logic          tick_s, clear_s;
  logic [TW-1:0] count_s;

  assign clear_s = (state_r == IDLE) || (state_r == FETCH) || (state_r == LOAD);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(clear_s),
    .tick (tick_s),
    .count(count_s)
  );

`ifdef FIFO_UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
  logic parity_r;

  // Parity is fixed at load time, before the shifter consumes the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_r <= 1'b0;
    end else if (state_r == LOAD) begin
      parity_r <= even_parity(PARITY_MAX_W'(fifo_data));
    end else begin
      parity_r <= parity_r;
    end
  end
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif

  // Next state, datapath and next output values; outputs are derived from the next state.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (en && !fifo_empty) state_s = FETCH;
        else                   state_s = IDLE;
      end
      FETCH: state_s = LOAD;
      LOAD: begin
        shift_s = fifo_data;
        idx_s   = IDX_ZERO;
        state_s = START;
      end
      START: begin
        if (tick_s) state_s = DATA;
        else        state_s = START;
      end
      DATA: begin
        if (tick_s) begin
          shift_s = {1'b0, shift_r[M-1:1]};
          if (idx_r == IDX_DATA_LAST) begin
            idx_s   = IDX_ZERO;
            state_s = AFTER_DATA;
          end else begin
            idx_s   = idx_r + IDX_ONE;
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (tick_s) state_s = STOP;
        else        state_s = PARITY;
      end
      STOP: begin
        if (tick_s && (idx_r == IDX_STOP_LAST)) begin
          idx_s   = IDX_ZERO;
          state_s = IDLE;
        end else if (tick_s) begin
          idx_s   = idx_r + IDX_ONE;
          state_s = STOP;
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase

    tx_s = TX_IDLE_LEVEL;
    case (state_s)
      START:  tx_s = TX_START_LEVEL;
      DATA:   tx_s = shift_s[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_s = parity_r;
`else
      PARITY: tx_s = TX_IDLE_LEVEL;
`endif
      default: tx_s = TX_IDLE_LEVEL;
    endcase

    rd_s   = (state_s == FETCH);
    busy_s = (state_s != IDLE);
    done_s = (state_r == STOP) && (count_s == CNT_PRE_LAST) && (idx_r == IDX_STOP_LAST);
  end

  // State, datapath and registered outputs; reset drops the frame and idles the line at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= {M{1'b0}};
      idx_r      <= IDX_ZERO;
      tx         <= TX_IDLE_LEVEL;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      idx_r      <= idx_s;
      tx         <= tx_s;
      fifo_rd    <= rd_s;
      busy       <= busy_s;
      frame_done <= done_s;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx (M=8, CLKS_PER_BIT=4, one stop bit).
// Models a registered-output FIFO; honours FIFO_UART_TX_PARITY_EN for the expected frame.
module tb_fifo_uart_tx;

  localparam int unsigned M         = 8;
  localparam int unsigned CPB       = 4;
  localparam int unsigned STOP_BITS = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int unsigned PAR_BITS  = 1;
`else
  localparam int unsigned PAR_BITS  = 0;
`endif
  localparam int unsigned FRAME_LEN = (1 + M + PAR_BITS + STOP_BITS) * CPB;

  logic         clk;
  logic         rst;
  logic         en;
  logic         fifo_empty;
  logic [M-1:0] fifo_data;
  logic         fifo_rd;
  logic         tx;
  logic         busy;
  logic         frame_done;

  logic [M-1:0] q[$];
  int checks;
  int errors;
  int rd_count;
  int done_count;

  fifo_uart_tx #(
    .M           (M),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (STOP_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: FIFO model answers a pop with registered data, otherwise data wanders.
  task automatic step();
    logic rd_pre;
    rd_pre = fifo_rd;
    @(posedge clk);
    #1;
    if (rd_pre) begin
      chk("underflow_pop", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) fifo_data = q.pop_front();
      fifo_empty = (q.size() == 0);
    end else begin
      fifo_data = fifo_data ^ 8'h5A;
    end
    rd_count   += int'(fifo_rd);
    done_count += int'(frame_done);
  endtask

  function automatic logic [63:0] exp_frame(input logic [M-1:0] w);
    logic [63:0] v;
    int b;
    v = 64'd0;
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      b = k / int'(CPB);
      if (b == 0)                                   v[k] = 1'b0;
      else if (b <= int'(M))                        v[k] = w[b-1];
      else if (PAR_BITS == 1 && b == int'(M) + 1)   v[k] = ^w;
      else                                          v[k] = 1'b1;
    end
    return v;
  endfunction

  task automatic wait_start(input string tag, output int high);
    bit found;
    found = 1'b0;
    high  = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      if (tx === 1'b0) found = 1'b1;
      else             high++;
    end
    chk({tag, "_start"}, 64'(found), 64'd1);
  endtask

  // Records tx/frame_done/busy for one frame starting at the current (start-bit) sample.
  task automatic capture(input logic [M-1:0] w, input int drop_at, input string tag);
    logic [63:0] tx_v, done_v, busy_v;
    tx_v = 64'd0; done_v = 64'd0; busy_v = 64'd0;
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      if (k > 0) step();
      tx_v[k]   = tx;
      done_v[k] = frame_done;
      busy_v[k] = busy;
      if (k == drop_at) en = 1'b0;
    end
    chk({tag, "_tx_frame"}, tx_v, exp_frame(w));
    chk({tag, "_frame_done"}, done_v, 64'd1 << (FRAME_LEN - 1));
    chk({tag, "_busy"}, busy_v, (64'd1 << FRAME_LEN) - 64'd1);
  endtask

  initial begin
    int gap;
    int rd0;
    int done0;
    int bad_tx;
    int bad_busy;
    checks = 0; errors = 0; rd_count = 0; done_count = 0;
    rst = 1'b1; en = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h00;

    step(); step();
    chk("reset_tx", 64'(tx), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_fifo_rd", 64'(fifo_rd), 64'd0);
    chk("reset_frame_done", 64'(frame_done), 64'd0);
    rst = 1'b0;

    // Enabled but empty: nothing may be popped or sent.
    en = 1'b1; bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("idle_rd_pulses", 64'(rd_count), 64'd0);
    chk("idle_tx_low_cycles", 64'(bad_tx), 64'd0);
    chk("idle_busy_cycles", 64'(bad_busy), 64'd0);

    // Single frames.
    q.push_back(8'hA5); fifo_empty = 1'b0; rd0 = rd_count; done0 = done_count;
    wait_start("a5", gap);
    capture(8'hA5, -1, "a5");
    repeat (6) step();
    chk("a5_rd_pulses", 64'(rd_count - rd0), 64'd1);
    chk("a5_done_pulses", 64'(done_count - done0), 64'd1);
    chk("a5_after_tx", 64'(tx), 64'd1);
    chk("a5_after_busy", 64'(busy), 64'd0);

    q.push_back(8'h07); fifo_empty = 1'b0; rd0 = rd_count;
    wait_start("w07", gap);
    capture(8'h07, -1, "w07");
    repeat (6) step();
    chk("w07_rd_pulses", 64'(rd_count - rd0), 64'd1);

    // Back-to-back frames with the minimum three-cycle idle gap.
    q.push_back(8'h01); q.push_back(8'h80); q.push_back(8'hFF);
    fifo_empty = 1'b0; rd0 = rd_count; done0 = done_count;
    wait_start("b2b0", gap);
    capture(8'h01, -1, "b2b0");
    wait_start("b2b1", gap);
    chk("b2b1_gap", 64'(gap), 64'd3);
    capture(8'h80, -1, "b2b1");
    wait_start("b2b2", gap);
    chk("b2b2_gap", 64'(gap), 64'd3);
    capture(8'hFF, -1, "b2b2");
    repeat (20) step();
    chk("b2b_rd_pulses", 64'(rd_count - rd0), 64'd3);
    chk("b2b_done_pulses", 64'(done_count - done0), 64'd3);
    chk("b2b_after_busy", 64'(busy), 64'd0);

    // en dropped during data bit 3: frame finishes, second word stays queued.
    q.push_back(8'hC3); q.push_back(8'h3C);
    fifo_empty = 1'b0; rd0 = rd_count; done0 = done_count;
    wait_start("endrop", gap);
    capture(8'hC3, 17, "endrop");
    bad_tx = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tx !== 1'b1) bad_tx++;
    end
    chk("endrop_rd_pulses", 64'(rd_count - rd0), 64'd1);
    chk("endrop_done_pulses", 64'(done_count - done0), 64'd1);
    chk("endrop_tx_low_cycles", 64'(bad_tx), 64'd0);
    chk("endrop_busy", 64'(busy), 64'd0);
    q.delete(); fifo_empty = 1'b1; en = 1'b1;

    // Reset during data bit 5 (0x96 bit 5 is 0, so the line must jump high).
    q.push_back(8'h96); fifo_empty = 1'b0; rd0 = rd_count; done0 = done_count;
    wait_start("rstmid", gap);
    for (int k = 1; k <= 25; k++) step();
    chk("rstmid_pre_tx", 64'(tx), 64'd0);
    rst = 1'b1;
    #1;
    chk("rstmid_async_tx", 64'(tx), 64'd1);
    chk("rstmid_async_busy", 64'(busy), 64'd0);
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    chk("rstmid_no_done", 64'(done_count - done0), 64'd0);
    chk("rstmid_rd_pulses", 64'(rd_count - rd0), 64'd1);
    q.push_back(8'h4B); fifo_empty = 1'b0;
    wait_start("postrst", gap);
    capture(8'h4B, -1, "postrst");
    repeat (6) step();
    chk("postrst_rd_pulses", 64'(rd_count - rd0), 64'd2);
    chk("postrst_done_pulses", 64'(done_count - done0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
